// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: byte-stream front end for aes_core.
// Collects 16 rx bytes into a block and starts the core with a latched key and mode.
// It then waits, with a timeout, for the result and streams it back out as 16 tx bytes.
module aes_stream_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic [127:0] key_in,
  input  logic         mode_in,
  input  logic [7:0]   rx_data_in,
  input  logic         rx_valid_in,
  output logic         rx_ready_out,
  output logic [7:0]   tx_data_out,
  output logic         tx_valid_out,
  input  logic         tx_ready_in,
  output logic         aes_init_out,
  output logic         aes_mode_out,
  output logic [127:0] aes_data_out,
  output logic [127:0] aes_key_out,
  input  logic [127:0] aes_data_in,
  input  logic         aes_valid_in,
  output logic         busy_out,
  output logic         error_out,
  output logic [15:0]  block_count_out
);

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_START,
    ST_WAIT,
    ST_SEND
  } state_e;

  // Timer value seen in the last allowed WAIT cycle; the error flop then rises
  // exactly TIMEOUT_CYCLES cycles after WAIT entry.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [119:0]   rx_buf_q, rx_buf_d;    // first 15 bytes; byte 16 joins on the fly
  logic [127:0]   tx_sr_q, tx_sr_d;
  logic [15:0]    timer_q, timer_d;
  logic [127:0]   aes_data_q, aes_data_d;
  logic [127:0]   aes_key_q, aes_key_d;
  logic           aes_mode_q, aes_mode_d;
  logic           aes_init_q, aes_init_d;
  logic           error_q, error_d;
  logic [15:0]    block_count_q, block_count_d;

  // Next-state and datapath updates for the collect/start/wait/send sequence
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    rx_buf_d      = rx_buf_q;
    tx_sr_d       = tx_sr_q;
    timer_d       = timer_q;
    aes_data_d    = aes_data_q;
    aes_key_d     = aes_key_q;
    aes_mode_d    = aes_mode_q;
    aes_init_d    = 1'b0;
    error_d       = 1'b0;
    block_count_d = block_count_q;
    case (state_q)
      ST_COLLECT: begin
        if (rx_valid_in) begin
          rx_buf_d = {rx_buf_q[111:0], rx_data_in};
          idx_d    = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            aes_data_d = {rx_buf_q, rx_data_in};
            aes_key_d  = key_in;
            aes_mode_d = mode_in;
            aes_init_d = 1'b1;
            state_d    = ST_START;
          end
        end
      end
      ST_START: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + 16'd1;
        if (aes_valid_in) begin
          tx_sr_d       = aes_data_in;
          block_count_d = block_count_q + 16'd1;
          state_d       = ST_SEND;
        end else if (timer_q == TMO_LAST) begin
          error_d = 1'b1;
          state_d = ST_COLLECT;
        end
      end
      ST_SEND: begin
        if (tx_ready_in) begin
          tx_sr_d = {tx_sr_q[119:0], 8'h00};
          idx_d   = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_d = ST_COLLECT;
          end
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= ST_COLLECT;
      idx_q         <= '0;
      rx_buf_q      <= '0;
      tx_sr_q       <= '0;
      timer_q       <= '0;
      aes_data_q    <= '0;
      aes_key_q     <= '0;
      aes_mode_q    <= 1'b0;
      aes_init_q    <= 1'b0;
      error_q       <= 1'b0;
      block_count_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      rx_buf_q      <= rx_buf_d;
      tx_sr_q       <= tx_sr_d;
      timer_q       <= timer_d;
      aes_data_q    <= aes_data_d;
      aes_key_q     <= aes_key_d;
      aes_mode_q    <= aes_mode_d;
      aes_init_q    <= aes_init_d;
      error_q       <= error_d;
      block_count_q <= block_count_d;
    end
  end

  assign rx_ready_out    = (state_q == ST_COLLECT);
  assign tx_valid_out    = (state_q == ST_SEND);
  assign busy_out        = (state_q != ST_COLLECT) || (idx_q != 4'd0);
  assign tx_data_out     = tx_sr_q[127:120];
  assign aes_init_out    = aes_init_q;
  assign aes_mode_out    = aes_mode_q;
  assign aes_data_out    = aes_data_q;
  assign aes_key_out     = aes_key_q;
  assign error_out       = error_q;
  assign block_count_out = block_count_q;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Directed bench for aes_stream_ctrl; the bench itself plays the role of aes_core.
module tb_aes_stream_ctrl;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk_in = 1'b0;
  logic         rst_n_in;
  logic [127:0] key_in;
  logic         mode_in;
  logic [7:0]   rx_data_in;
  logic         rx_valid_in;
  logic         rx_ready_out;
  logic [7:0]   tx_data_out;
  logic         tx_valid_out;
  logic         tx_ready_in;
  logic         aes_init_out;
  logic         aes_mode_out;
  logic [127:0] aes_data_out;
  logic [127:0] aes_key_out;
  logic [127:0] aes_data_in;
  logic         aes_valid_in;
  logic         busy_out;
  logic         error_out;
  logic [15:0]  block_count_out;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  aes_stream_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .key_in          (key_in),
    .mode_in         (mode_in),
    .rx_data_in      (rx_data_in),
    .rx_valid_in     (rx_valid_in),
    .rx_ready_out    (rx_ready_out),
    .tx_data_out     (tx_data_out),
    .tx_valid_out    (tx_valid_out),
    .tx_ready_in     (tx_ready_in),
    .aes_init_out    (aes_init_out),
    .aes_mode_out    (aes_mode_out),
    .aes_data_out    (aes_data_out),
    .aes_key_out     (aes_key_out),
    .aes_data_in     (aes_data_in),
    .aes_valid_in    (aes_valid_in),
    .busy_out        (busy_out),
    .error_out       (error_out),
    .block_count_out (block_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic rx_block(input logic [127:0] blk, input bit gaps);
    int unsigned n;
    for (int unsigned i = 0; i < 16; i++) begin
      if (gaps) begin
        n = $urandom_range(0, 2);
        for (int unsigned j = 0; j < n; j++) begin
          rx_valid_in = 1'b0;
          step();
        end
      end
      rx_valid_in = 1'b1;
      rx_data_in  = blk[127 - 8*i -: 8];
      step();
    end
    rx_valid_in = 1'b0;
  endtask

  task automatic run_block(input logic [127:0] key, input logic m, input logic [127:0] blk,
                           input logic [127:0] res, input int unsigned lat, input bit gaps,
                           input bit bp, input logic [15:0] exp_cnt);
    logic [7:0] exp_b;
    key_in  = key;
    mode_in = m;
    rx_block(blk, gaps);
    // now in START
    chk("init_pulse", 128'(aes_init_out), 128'(1'b1));
    chk("aes_data", aes_data_out, blk);
    chk("aes_key", aes_key_out, key);
    chk("aes_mode", 128'(aes_mode_out), 128'(m));
    chk("rx_ready_start", 128'(rx_ready_out), 128'(1'b0));
    chk("busy_start", 128'(busy_out), 128'(1'b1));
    key_in  = ~key;
    mode_in = ~m;
    step();
    chk("init_single", 128'(aes_init_out), 128'(1'b0));
    for (int unsigned k = 0; k < lat; k++) begin
      chk("mode_hold_wait", 128'(aes_mode_out), 128'(m));
      chk("key_hold_wait", aes_key_out, key);
      chk("rx_ready_wait", 128'(rx_ready_out), 128'(1'b0));
      chk("tx_valid_wait", 128'(tx_valid_out), 128'(1'b0));
      step();
    end
    aes_valid_in = 1'b1;
    aes_data_in  = res;
    step();
    aes_valid_in = 1'b0;
    aes_data_in  = '0;
    chk("no_error", 128'(error_out), 128'(1'b0));
    chk("tx_valid_rise", 128'(tx_valid_out), 128'(1'b1));
    chk("count", 128'(block_count_out), 128'(exp_cnt));
    for (int unsigned i = 0; i < 16; i++) begin
      exp_b = res[127 - 8*i -: 8];
      if (bp) begin
        tx_ready_in = 1'b0;
        chk("tx_byte_pre", 128'(tx_data_out), 128'(exp_b));
        step();
        chk("tx_byte_stable", 128'(tx_data_out), 128'(exp_b));
        chk("tx_valid_stable", 128'(tx_valid_out), 128'(1'b1));
      end
      chk("tx_byte", 128'(tx_data_out), 128'(exp_b));
      chk("rx_ready_send", 128'(rx_ready_out), 128'(1'b0));
      tx_ready_in = 1'b1;
      step();
      tx_ready_in = 1'b0;
    end
    chk("tx_valid_done", 128'(tx_valid_out), 128'(1'b0));
    chk("rx_ready_done", 128'(rx_ready_out), 128'(1'b1));
    chk("busy_done", 128'(busy_out), 128'(1'b0));
    chk("mode_hold_done", 128'(aes_mode_out), 128'(m));
    chk("count_done", 128'(block_count_out), 128'(exp_cnt));
  endtask

  initial begin
    rst_n_in     = 1'b0;
    key_in       = '0;
    mode_in      = 1'b0;
    rx_data_in   = '0;
    rx_valid_in  = 1'b0;
    tx_ready_in  = 1'b0;
    aes_data_in  = '0;
    aes_valid_in = 1'b0;
    step();
    step();
    rst_n_in = 1'b1;
    step();

    // reset state
    chk("rst_rx_ready", 128'(rx_ready_out), 128'(1'b1));
    chk("rst_tx_valid", 128'(tx_valid_out), 128'(1'b0));
    chk("rst_tx_data", 128'(tx_data_out), 128'(8'h00));
    chk("rst_busy", 128'(busy_out), 128'(1'b0));
    chk("rst_init", 128'(aes_init_out), 128'(1'b0));
    chk("rst_mode", 128'(aes_mode_out), 128'(1'b0));
    chk("rst_data", aes_data_out, 128'h0);
    chk("rst_key", aes_key_out, 128'h0);
    chk("rst_error", 128'(error_out), 128'(1'b0));
    chk("rst_count", 128'(block_count_out), 128'(16'h0000));

    // FIPS-197 encrypt, decrypt (valid on the timeout cycle), then backpressure with rx gaps
    run_block(KEY, 1'b1, PT, CT, 3, 1'b0, 1'b0, 16'd1);
    run_block(KEY, 1'b0, CT, PT, 7, 1'b0, 1'b0, 16'd2);
    run_block(KEY, 1'b1, PT, CT, 2, 1'b1, 1'b1, 16'd3);

    // timeout with the core silent
    key_in  = KEY;
    mode_in = 1'b1;
    rx_block(PT, 1'b0);
    chk("tmo_init", 128'(aes_init_out), 128'(1'b1));
    step();
    for (int unsigned k = 0; k < 8; k++) begin
      chk("tmo_no_error_early", 128'(error_out), 128'(1'b0));
      chk("tmo_rx_ready_low", 128'(rx_ready_out), 128'(1'b0));
      chk("tmo_no_tx", 128'(tx_valid_out), 128'(1'b0));
      step();
    end
    chk("tmo_error", 128'(error_out), 128'(1'b1));
    chk("tmo_rx_ready", 128'(rx_ready_out), 128'(1'b1));
    chk("tmo_no_tx_after", 128'(tx_valid_out), 128'(1'b0));
    chk("tmo_count", 128'(block_count_out), 128'(16'd3));
    step();
    chk("tmo_error_single", 128'(error_out), 128'(1'b0));
    chk("tmo_busy", 128'(busy_out), 128'(1'b0));

    // reset mid-block after 7 bytes
    key_in  = KEY;
    mode_in = 1'b1;
    for (int unsigned i = 0; i < 7; i++) begin
      rx_valid_in = 1'b1;
      rx_data_in  = 8'hA0 + 8'(i);
      step();
    end
    rx_valid_in = 1'b0;
    chk("partial_busy", 128'(busy_out), 128'(1'b1));
    rst_n_in = 1'b0;
    #1;
    chk("async_busy", 128'(busy_out), 128'(1'b0));
    chk("async_data", aes_data_out, 128'h0);
    chk("async_count", 128'(block_count_out), 128'(16'h0000));
    chk("async_rx_ready", 128'(rx_ready_out), 128'(1'b1));
    step();
    rst_n_in = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      chk("no_init_after_rst", 128'(aes_init_out), 128'(1'b0));
      step();
    end
    run_block(KEY, 1'b1, PT, CT, 4, 1'b0, 1'b0, 16'd1);

    // counter wrap
    force dut.block_count_q = 16'hFFFF;
    step();
    release dut.block_count_q;
    step();
    chk("preload_count", 128'(block_count_out), 128'(16'hFFFF));
    run_block(KEY, 1'b1, PT, CT, 1, 1'b0, 1'b0, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aes_stream_ctrl.md
# aes_stream_ctrl

Byte-stream initiator for `aes_core`. Assembles 16 received bytes into a 128-bit block and issues one `init` pulse with that block, a latched key and a latched mode. It then waits for the core's `valid`, captures the result and serializes it back out as 16 bytes. It sits between a byte-wide transport, such as the UART receive/transmit path, and `aes_core`, and owns the core's entire control side.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles spent in WAIT before the block is aborted. Legal range 1..65535.

Ports:
- `clk_in` input 1: system clock.
- `rst_n_in` input 1: asynchronous, active-low reset.
- `key_in` input 128: cipher key, sampled on the 16th rx byte.
- `mode_in` input 1: 1 = ENCRYPT, 0 = DECRYPT, sampled on the 16th rx byte.
- `rx_data_in` input 8: incoming byte.
- `rx_valid_in` input 1: incoming byte valid.
- `rx_ready_out` output 1: ready to accept a byte.
- `tx_data_out` output 8: outgoing byte.
- `tx_valid_out` output 1: outgoing byte valid.
- `tx_ready_in` input 1: downstream accepts the byte.
- `aes_init_out` output 1: one-cycle start pulse to the core.
- `aes_mode_out` output 1: mode to the core.
- `aes_data_out` output 128: block to the core.
- `aes_key_out` output 128: key to the core.
- `aes_data_in` input 128: result from the core.
- `aes_valid_in` input 1: result valid from the core.
- `busy_out` output 1: high whenever a block is in flight, including a partial rx.
- `error_out` output 1: one-cycle pulse on timeout.
- `block_count_out` output 16: number of completed blocks; wraps 0xFFFF -> 0.

## Operation

- States: COLLECT, START, WAIT, SEND. Reset state is COLLECT.
- Byte order: the first byte received fills bits [127:120] (FIPS-197 byte 0). The first byte transmitted is result bits [127:120].
- **COLLECT**
  - `rx_ready_out` = 1.
  - Each handshake (`rx_valid_in` && `rx_ready_out`) shifts the buffer left by 8, loads `rx_data_in` into [7:0] and increments a 4-bit byte index.
  - On the handshake with index = 15:
    - the completed block is registered to `aes_data_out`;
    - `key_in` -> `aes_key_out` and `mode_in` -> `aes_mode_out`;
    - the index returns to 0 and the state goes to START.
- **START**
  - `aes_init_out` = 1 for exactly this one cycle, then WAIT.
  - The wait timer is cleared.
- **WAIT**
  - The timer increments every cycle.
  - If `aes_valid_in` = 1: capture `aes_data_in` into the tx shift register, increment `block_count_out`, go to SEND.
  - Otherwise, when the timer reaches `TIMEOUT_CYCLES`: pulse `error_out` for 1 cycle, discard the block, return to COLLECT. `block_count_out` is unchanged.
  - If valid and timeout coincide, valid wins and there is no error.
- **SEND**
  - `tx_valid_out` = 1 and `tx_data_out` = shift register [127:120].
  - On each handshake the register shifts left by 8 and the index increments.
  - After the 16th handshake, go to COLLECT.
  - `tx_valid_out` and `tx_data_out` stay stable until accepted.
- `rx_ready_out` = 0 in START, WAIT and SEND. There is no overlap of rx with an in-flight block.
- `aes_mode_out`, `aes_key_out` and `aes_data_out` are held constant from START until the next 16th rx byte. The core muxes on mode combinationally, so mode must not move mid-operation.
- `aes_valid_in` outside WAIT is ignored.
- `busy_out` = (state != COLLECT) || (byte index != 0).

## Timing

- All outputs are registered except `rx_ready_out`, `tx_valid_out` and `busy_out`, which are decoded from state.
- Reset values:
  - state COLLECT, indices 0, timer 0;
  - all `aes_*` outputs 0, `tx_data_out` 0, `error_out` 0, `block_count_out` 0;
  - `tx_valid_out` 0 and `rx_ready_out` 1 once reset is deasserted.
- Latency:
  - `aes_init_out` rises the cycle after the 16th rx handshake;
  - `tx_valid_out` rises the cycle after `aes_valid_in` is sampled in WAIT.
- Minimum block period: 16 rx + 1 START + core latency + 1 + 16 tx cycles.
- Asserting `rst_n_in` mid-operation (any state):
  - immediately forces the reset values;
  - partial rx bytes and untransmitted result bytes are discarded;
  - no `aes_init_out` pulse is emitted after deassertion until 16 new bytes arrive.
- Timeout: `error_out` fires `TIMEOUT_CYCLES` cycles after entry to WAIT. `rx_ready_out` returns to 1 on the next cycle.

## Test plan

- **FIPS-197 encrypt:** key 000102030405060708090a0b0c0d0e0f, mode 1, rx 00 11 22 … ff back-to-back.
  - One `aes_init_out` pulse with `aes_data_out` = 00112233445566778899aabbccddeeff.
  - tx bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a.
  - `block_count_out` = 1.
- **FIPS-197 decrypt:** same key, mode 0, rx the ciphertext above.
  - tx 00 11 22 … ff.
  - `aes_mode_out` held at 0 through WAIT.
- **Backpressure and gaps:** `tx_ready_in` toggling 1010… during SEND and random `rx_valid_in` gaps.
  - `tx_data_out` stable while unaccepted; same 16 bytes delivered in order.
  - `rx_ready_out` = 0 throughout WAIT and SEND.
- **Timeout:** `TIMEOUT_CYCLES` = 8 with `aes_valid_in` tied 0.
  - `error_out` pulses exactly 8 cycles after WAIT entry.
  - No tx bytes; `block_count_out` unchanged; `rx_ready_out` = 1 next cycle.
- **Reset mid-block:** assert `rst_n_in` after 7 rx bytes, then deassert and send 16 bytes of the FIPS-197 plaintext.
  - Result matches the first scenario; no stale bytes in `aes_data_out`.
- **Counter wrap:** preload via 65536 blocks, or force the counter to 0xFFFF, then complete one block.
  - `block_count_out` = 0x0000.
